// File: rtl/slice_data_streamer_if.sv
// Slice descriptor and payload word bus between the header parser, the streamer and the
// macroblock decoder.
interface slice_data_streamer_if #(
  parameter int NAL_W  = 3072,
  parameter int WORD_W = 64,
  parameter int POS_W  = 12
);
  logic [NAL_W-1:0]  nal_unit;
  logic [POS_W-1:0]  nal_bits;
  logic [POS_W-1:0]  bit_pos;
  logic              in_valid;
  logic              in_ready;
  logic              abort;
  logic [WORD_W-1:0] out_data;
  logic [POS_W-1:0]  out_bits;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  logic [POS_W-1:0]  word_cnt;
  logic              done;
  logic              err;

  modport master (
    output nal_unit, nal_bits, bit_pos, in_valid, abort, out_ready,
    input  in_ready, out_data, out_bits, out_last, out_valid, word_cnt, done, err
  );

  modport slave (
    input  nal_unit, nal_bits, bit_pos, in_valid, abort, out_ready,
    output in_ready, out_data, out_bits, out_last, out_valid, word_cnt, done, err
  );
endinterface

// File: rtl/slice_data_streamer.sv
// Strips the slice header from an RBSP buffer and streams the payload LSB-first as
// fixed-width words with last-word bit count, done/err pulses and abort.
module slice_data_streamer #(
  parameter int NAL_W  = 3072,
  parameter int WORD_W = 64,
  parameter int POS_W  = 12
) (
  input  logic                clk,
  input  logic                rst,
  slice_data_streamer_if.slave bus
);

  localparam logic [POS_W-1:0] LP_NAL_BITS  = POS_W'(NAL_W);
  localparam logic [POS_W-1:0] LP_WORD_BITS = POS_W'(WORD_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [NAL_W-1:0]  r_buf;
  logic [POS_W-1:0]  r_remaining;
  logic [POS_W-1:0]  r_word_cnt;
  logic              w_load;
  logic              w_shift;
  logic              w_bad;
  logic              w_last;
  logic              w_stream;

  // Keep only bits below nbits, then drop the header; a shift of NAL_W yields an all-ones mask.
  function automatic logic [NAL_W-1:0] f_payload(input logic [NAL_W-1:0] nal,
                                                 input logic [POS_W-1:0] nbits,
                                                 input logic [POS_W-1:0] pos);
    logic [NAL_W-1:0] mask;
    mask = ~({NAL_W{1'b1}} << nbits);
    return (nal & mask) >> pos;
  endfunction

  // Next-state and datapath control decode.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_last       = (r_remaining <= LP_WORD_BITS);
    w_bad        = (bus.nal_bits == {POS_W{1'b0}}) || (bus.nal_bits > LP_NAL_BITS) ||
                   (bus.bit_pos >= bus.nal_bits);
    if (bus.abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (w_bad) begin
              w_next_state = S_ERR;
            end else begin
              w_load       = 1'b1;
              w_next_state = S_STREAM;
            end
          end else begin
            w_next_state = S_IDLE;
          end
        end
        S_STREAM: begin
          if (bus.out_ready) begin
            w_shift      = 1'b1;
            w_next_state = w_last ? S_DONE : S_STREAM;
          end else begin
            w_next_state = S_STREAM;
          end
        end
        S_DONE:  w_next_state = S_IDLE;
        S_ERR:   w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Payload buffer, remaining bit count and accepted word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf       <= {NAL_W{1'b0}};
      r_remaining <= {POS_W{1'b0}};
      r_word_cnt  <= {POS_W{1'b0}};
    end else if (bus.abort) begin
      r_buf       <= {NAL_W{1'b0}};
      r_remaining <= {POS_W{1'b0}};
    end else if (w_load) begin
      r_buf       <= f_payload(bus.nal_unit, bus.nal_bits, bus.bit_pos);
      r_remaining <= bus.nal_bits - bus.bit_pos;
      r_word_cnt  <= {POS_W{1'b0}};
    end else if (w_shift) begin
      r_buf       <= r_buf >> WORD_W;
      r_remaining <= w_last ? {POS_W{1'b0}} : (r_remaining - LP_WORD_BITS);
      r_word_cnt  <= r_word_cnt + POS_W'(1);
    end else begin
      r_buf       <= r_buf;
      r_remaining <= r_remaining;
      r_word_cnt  <= r_word_cnt;
    end
  end

  // Outputs are pure decodes of registers; outside STREAM the word fields read as zero.
  assign w_stream      = (r_state == S_STREAM);
  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = w_stream;
  assign bus.out_data  = w_stream ? r_buf[WORD_W-1:0] : {WORD_W{1'b0}};
  assign bus.out_last  = w_stream && w_last;
  assign bus.out_bits  = !w_stream ? {POS_W{1'b0}} : (w_last ? r_remaining : LP_WORD_BITS);
  assign bus.word_cnt  = r_word_cnt;
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = (r_state == S_ERR);

endmodule

// File: tb/tb_slice_data_streamer.sv
// Directed bench for slice_data_streamer: a bit-level payload model fills a scoreboard
// that is drained as the DUT hands words over.
module tb_slice_data_streamer;

  localparam int NAL_W  = 3072;
  localparam int WORD_W = 64;
  localparam int POS_W  = 12;

  typedef struct {
    logic [63:0] data;
    logic [11:0] bits;
    logic        last;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [NAL_W-1:0]  nal;
  exp_t              sb[$];
  int                n_tests;
  int                n_fail;
  int                tot_bits;

  slice_data_streamer_if #(.NAL_W(NAL_W), .WORD_W(WORD_W), .POS_W(POS_W)) bus ();

  slice_data_streamer #(.NAL_W(NAL_W), .WORD_W(WORD_W), .POS_W(POS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NAL_W / 32; i++) nal[i*32 +: 32] = $urandom();
  endtask

  // Bit-by-bit reference: payload bit k is nal[pos+k] for k < nbits-pos.
  task automatic push_model(input int nbits, input int pos);
    exp_t e;
    int   len;
    int   nwords;
    len    = nbits - pos;
    nwords = (len + WORD_W - 1) / WORD_W;
    for (int w = 0; w < nwords; w++) begin
      e.data = 64'd0;
      for (int j = 0; j < WORD_W; j++) begin
        if (w * WORD_W + j < len) e.data[j] = nal[pos + w * WORD_W + j];
      end
      e.last = (w == nwords - 1);
      e.bits = e.last ? 12'(len - w * WORD_W) : 12'd64;
      sb.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input int nbits, input int pos, input bit good);
    chk("send_in_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.nal_unit = nal;
    bus.nal_bits = 12'(nbits);
    bus.bit_pos  = 12'(pos);
    bus.in_valid = 1'b1;
    if (good) push_model(nbits, pos);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (good) begin
      chk("first_word_latency", {63'd0, bus.out_valid}, 64'd1);
      chk("word_cnt_start", {52'd0, bus.word_cnt}, 64'd0);
    end
  endtask

  task automatic stream_slice(input bit rnd, input int stall_at);
    exp_t        e;
    int          n_exp;
    int          cyc;
    logic        stalled;
    logic        r;
    logic [63:0] s_data;
    logic [11:0] s_bits;
    logic        s_last;
    n_exp    = sb.size();
    cyc      = 0;
    stalled  = 1'b0;
    tot_bits = 0;
    while (sb.size() > 0 && cyc < 2000) begin
      if (stalled) begin
        chk("stall_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("stall_data", bus.out_data, s_data);
        chk("stall_bits", {52'd0, bus.out_bits}, {52'd0, s_bits});
        chk("stall_last", {63'd0, bus.out_last}, {63'd0, s_last});
      end
      if (cyc >= stall_at && cyc < stall_at + 5) r = 1'b0;
      else if (rnd) r = 1'($urandom_range(0, 1));
      else r = 1'b1;
      bus.out_ready = r;
      if (bus.out_valid && r) begin
        e = sb.pop_front();
        chk("word_data", bus.out_data, e.data);
        chk("word_bits", {52'd0, bus.out_bits}, {52'd0, e.bits});
        chk("word_last", {63'd0, bus.out_last}, {63'd0, e.last});
        tot_bits += int'(bus.out_bits);
      end
      stalled = bus.out_valid && !r;
      s_data  = bus.out_data;
      s_bits  = bus.out_bits;
      s_last  = bus.out_last;
      cyc++;
      @(negedge clk);
    end
    chk("stream_timeout", 64'(sb.size()), 64'd0);
    bus.out_ready = 1'b0;
    chk("done_pulse", {63'd0, bus.done}, 64'd1);
    chk("done_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("done_word_cnt", {52'd0, bus.word_cnt}, 64'(n_exp));
    @(negedge clk);
    chk("done_cleared", {63'd0, bus.done}, 64'd0);
    chk("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("idle_word_cnt", {52'd0, bus.word_cnt}, 64'(n_exp));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
    chk({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
    chk({tag, "_out_last"}, {63'd0, bus.out_last}, 64'd0);
    chk({tag, "_out_data"}, bus.out_data, 64'd0);
    chk({tag, "_out_bits"}, {52'd0, bus.out_bits}, 64'd0);
    chk({tag, "_word_cnt"}, {52'd0, bus.word_cnt}, 64'd0);
    chk({tag, "_done"}, {63'd0, bus.done}, 64'd0);
    chk({tag, "_err"}, {63'd0, bus.err}, 64'd0);
  endtask

  initial begin
    exp_t e;
    int   bad_bits[3];
    int   bad_pos[3];
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    nal           = '0;
    bus.nal_unit  = '0;
    bus.nal_bits  = 12'd0;
    bus.bit_pos   = 12'd0;
    bus.in_valid  = 1'b0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("post_reset");

    // 200 bits, header 40: words of 64, 64, 32
    fill_random();
    send(200, 40, 1'b1);
    chk("t1_words", 64'(sb.size()), 64'd3);
    stream_slice(1'b0, 10000);
    chk("t1_total_bits", 64'(tot_bits), 64'd160);

    // Full buffer, no header
    fill_random();
    send(3072, 0, 1'b1);
    stream_slice(1'b0, 10000);
    chk("t2_total_bits", 64'(tot_bits), 64'd3072);

    // Rejected descriptors
    bad_bits = '{200, 0, 3073};
    bad_pos  = '{200, 0, 0};
    for (int i = 0; i < 3; i++) begin
      send(bad_bits[i], bad_pos[i], 1'b0);
      chk("err_pulse", {63'd0, bus.err}, 64'd1);
      chk("err_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("err_in_ready", {63'd0, bus.in_ready}, 64'd0);
      @(negedge clk);
      chk("err_cleared", {63'd0, bus.err}, 64'd0);
      chk("err_back_idle", {63'd0, bus.in_ready}, 64'd1);
      chk("err_valid2", {63'd0, bus.out_valid}, 64'd0);
    end

    // Backpressure with random ready and a 5-cycle stall
    fill_random();
    send(300, 8, 1'b1);
    stream_slice(1'b1, 3);
    chk("bp_total_bits", 64'(tot_bits), 64'd292);

    // Abort while word 2 of a 5-word slice is offered
    fill_random();
    send(300, 8, 1'b1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      chk("abort_pre_word", bus.out_data, e.data);
      @(negedge clk);
    end
    chk("abort_word2", bus.out_data, sb[0].data);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    chk("abort_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("abort_idle", {63'd0, bus.in_ready}, 64'd1);
    chk("abort_no_done", {63'd0, bus.done}, 64'd0);
    chk("abort_word_cnt", {52'd0, bus.word_cnt}, 64'd2);
    sb.delete();
    fill_random();
    send(200, 40, 1'b1);
    stream_slice(1'b0, 10000);

    // Abort together with a descriptor in IDLE drops it
    bus.nal_bits = 12'd200;
    bus.bit_pos  = 12'd0;
    bus.in_valid = 1'b1;
    bus.abort    = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    chk("abort_idle_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("abort_idle_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("abort_idle_err", {63'd0, bus.err}, 64'd0);

    // Asynchronous reset between clock edges mid-stream
    fill_random();
    send(300, 8, 1'b1);
    bus.out_ready = 1'b1;
    e = sb.pop_front();
    chk("rst_pre_word", bus.out_data, e.data);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("async_rst");
    sb.delete();
    bus.out_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_reset_values("rst_release");
    fill_random();
    send(260, 4, 1'b1);
    stream_slice(1'b1, 1);
    chk("rst_resume_bits", 64'(tot_bits), 64'd256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
